mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed request-to-response latency.
// Optional MEM_RESP_ERR_EN: flag out-of-range addresses instead of wrapping them.
module mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept_c;
  logic               commit_c;
  logic               release_c;
  logic               addr_err_c;
  logic [IDX_W-1:0]   idx_c;

  assign req_ready_o = (state == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    commit_c  = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept_c  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit_c  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          release_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address decode of the captured request
  always_comb begin
    idx_c = IDX_W'(32'(addr_q) % DEPTH);
`ifdef MEM_RESP_ERR_EN
    addr_err_c = (32'(addr_q) >= DEPTH);
`else
    addr_err_c = 1'b0;
`endif
  end

  // Request capture; only meaningful while an operation is pending
  always_ff @(posedge clk) begin
    if (accept_c) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt <= CNT_W'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit_c) begin
        resp_valid_o <= 1'b1;
        resp_err_o   <= addr_err_c;
        resp_rdata_o <= (we_q || addr_err_c) ? '0 : mem[idx_c];
      end else if (release_c) begin
        resp_valid_o <= 1'b0;
      end
    end
  end

  // Storage is never reset; a reset on the commit edge still aborts the write
  always_ff @(posedge clk) begin
    if (!rst && commit_c && we_q && !addr_err_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against an address-map reference model.
module tb_mem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEP   = 1024;
  localparam int unsigned LAT   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [int];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            ready_mode = 1;
  logic          prev_valid = 1'b0;
  logic [AW-1:0] pool [8] = '{16'h0000, 16'h0010, 16'h0020, 16'h0123,
                              16'h03ff, 16'h0200, 16'h0001, 16'h0155};

  always @(posedge clk) cyc <= cyc + 1;

  // Response back-pressure: random, forced on, or forced off
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       resp_ready_i = ($urandom_range(0, 3) != 0);
      1:       resp_ready_i = 1'b1;
      default: resp_ready_i = 1'b0;
    endcase
  end

  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic tmo(input string n);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=event", n);
  endtask

  // Reference model: word memory of DEP entries, optional range error
  task automatic push_exp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    exp_t e;
    int   idx;
    logic err;
    idx = int'(addr) % DEP;
`ifdef MEM_RESP_ERR_EN
    err = (int'(addr) >= DEP);
`else
    err = 1'b0;
`endif
    e.err = err;
    e.acc = cyc + 1;
    if (we) begin
      e.rdata = '0;
      if (!err) ref_mem[idx] = wd;
    end else begin
      e.rdata = err ? '0 : ref_mem[idx];
    end
    q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    while (!req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) tmo("accept_wait");
    else push_exp(we, addr, wd);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !req_ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !req_ready_o) tmo("drain");
  endtask

  // Monitor: latency on response rise, payload on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid_o && !prev_valid) begin
        if (q.size() == 0) tmo("unexpected_resp");
        else check("latency", 64'(cyc - q[0].acc), 64'(LAT));
      end
      if (resp_valid_o && resp_ready_i) begin
        if (q.size() == 0) tmo("unexpected_handshake");
        else begin
          mon_e = q.pop_front();
          check("rdata", 64'(resp_rdata_o), 64'(mon_e.rdata));
          check("err", 64'(resp_err_o), 64'(mon_e.err));
        end
      end
    end
    prev_valid = resp_valid_o;
  end

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] old20;
    logic [AW-1:0] a;
    int            n;
    int            prev_acc;

    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_rdata", 64'(resp_rdata_o), 64'd0);
    check("rst_err", 64'(resp_err_o), 64'd0);

    for (int i = 0; i < 8; i++) issue(1'b1, pool[i], $urandom);

    issue(1'b1, 16'h0010, 32'hDEADBEEF);
    issue(1'b0, 16'h0010, '0);

    issue(1'b1, 16'h0400, 32'hA5A5A5A5);
    issue(1'b0, 16'h0000, '0);
    issue(1'b0, 16'h0400, '0);
    wait_idle();

    // Response held under back-pressure
    ready_mode = 2;
    issue(1'b0, 16'h0123, '0);
    n = 0;
    while (!resp_valid_o && n < 50) begin @(negedge clk); n++; end
    if (!resp_valid_o) tmo("hold_valid");
    held = resp_rdata_o;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(resp_valid_o), 64'd1);
      check("hold_rdata", 64'(resp_rdata_o), 64'(held));
      check("hold_req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    ready_mode = 1;
    n = 0;
    while (!(resp_valid_o && resp_ready_i) && n < 50) begin @(negedge clk); n++; end
    if (!(resp_valid_o && resp_ready_i)) tmo("hold_release");
    @(negedge clk);
    check("hold_idle_ready", 64'(req_ready_o), 64'd1);
    check("hold_idle_valid", 64'(resp_valid_o), 64'd0);
    wait_idle();

    // Back-to-back reads with req_valid held high
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = pool[1];
    prev_acc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
      if (!req_ready_o) tmo("b2b_accept");
      push_exp(1'b0, req_addr_i, '0);
      if (k > 0) check("b2b_spacing", 64'(cyc - prev_acc), 64'(LAT + 2));
      prev_acc = cyc;
      @(negedge clk);
      req_addr_i = pool[(k + 2) % 8];
    end
    req_valid_i = 1'b0;
    wait_idle();

    // Reset while a write is still waiting to commit
    old20 = ref_mem[32];
    issue(1'b1, 16'h0020, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ref_mem[32] = old20;
    check("abort_resp_valid", 64'(resp_valid_o), 64'd0);
    check("abort_req_ready", 64'(req_ready_o), 64'd1);
    issue(1'b0, 16'h0020, '0);
    wait_idle();

    // Random traffic with back-pressure and ignored request noise
    ready_mode = 0;
    for (int t = 0; t < 150; t++) begin
      a = pool[$urandom_range(0, 7)] + AW'($urandom_range(0, 3) * 1024);
      issue(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, LAT + 3)) begin
        @(negedge clk);
        if (!req_ready_o) begin
          req_valid_i = 1'($urandom_range(0, 1));
          req_we_i    = 1'($urandom_range(0, 1));
          req_addr_i  = AW'($urandom);
          req_wdata_i = $urandom;
        end else begin
          req_valid_i = 1'b0;
        end
      end
      req_valid_i = 1'b0;
    end
    ready_mode = 1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
